dpram_be_clr: RTL

//  Parametrised single-clock true dual-port RAM: per-byte write enables, optional output register,

---
 rtl/dpram_pkg.sv | 11 +
 rtl/dpram_core.sv | 41 ++++
 rtl/dpram_be_clr.sv | 122 ++++++++++++
 3 files changed

// File: rtl/dpram_pkg.sv
// dpram_pkg: shared types and helpers for the byte-enabled dual-port RAM with clear engine.
package dpram_pkg;
  typedef enum logic {ST_RUN, ST_CLEAR} state_e;
  function automatic int be_w(input int dw);
    return dw / 8;
  endfunction
  function automatic logic [7:0] merge_be(input logic [7:0] old_b, input logic [7:0] nw_b,
                                          input logic be);
    return be ? nw_b : old_b;
  endfunction
endpackage

// File: rtl/dpram_core.sv
// dpram_core: bare 2**AW x DW array, two byte-enabled synchronous write-first ports, no reset.
module dpram_core
  import dpram_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic               clk,
  input  logic               re_a,
  input  logic [DW/8-1:0]    be_a,
  input  logic [AW-1:0]      ad_a,
  input  logic [DW-1:0]      wd_a,
  output logic [DW-1:0]      rd_a,
  input  logic               re_b,
  input  logic [DW/8-1:0]    be_b,
  input  logic [AW-1:0]      ad_b,
  input  logic [DW-1:0]      wd_b,
  output logic [DW-1:0]      rd_b
);
  localparam int BE_W = be_w(DW);
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] nw_a, nw_b, rd_a_q, rd_a_d, rd_b_q, rd_b_d;
  for (genvar i = 0; i < BE_W; i++) begin : g_lane
    assign nw_a[8*i+:8] = merge_be(mem[ad_a][8*i+:8], wd_a[8*i+:8], be_a[i]);
    assign nw_b[8*i+:8] = merge_be(mem[ad_b][8*i+:8], wd_b[8*i+:8], be_b[i]);
  end
  always_comb begin
    rd_a_d = re_a ? nw_a : rd_a_q;
    rd_b_d = re_b ? nw_b : rd_b_q;
  end
  always_ff @(posedge clk) begin
    for (int j = 0; j < BE_W; j++) begin
      if (be_a[j]) mem[ad_a][8*j+:8] <= wd_a[8*j+:8];
      if (be_b[j]) mem[ad_b][8*j+:8] <= wd_b[8*j+:8];
    end
    rd_a_q <= rd_a_d;
    rd_b_q <= rd_b_d;
  end
  assign rd_a = rd_a_q;
  assign rd_b = rd_b_q;
endmodule

// File: rtl/dpram_be_clr.sv
// dpram_be_clr: true dual-port RAM with byte enables, collision handling, optional output register and clear engine.
module dpram_be_clr
  import dpram_pkg::*;
#(
  parameter int          DW         = 32,
  parameter int          AW         = 10,
  parameter int          OUT_REG    = 0,
  parameter int          BYPASS     = 1,
  parameter int          CLR_ON_RST = 1,
  parameter logic [DW-1:0] CLR_VAL  = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_req,
  output logic            ready,
  input  logic            ena,
  input  logic [DW/8-1:0] wea,
  input  logic [AW-1:0]   aa,
  input  logic [DW-1:0]   wda,
  output logic [DW-1:0]   rda,
  output logic            rva,
  input  logic            enb,
  input  logic [DW/8-1:0] web,
  input  logic [AW-1:0]   ab,
  input  logic [DW-1:0]   wdb,
  output logic [DW-1:0]   rdb,
  output logic            rvb
);
  localparam int BE_W = be_w(DW);
  if (DW % 8 != 0 || AW < 1) begin : g_bad
    $error("dpram_be_clr: DW must be a multiple of 8 and AW must be at least 1");
  end
  state_e          st_q, st_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            ready_q, ready_d;
  logic            clr, acc_a, acc_b, coll;
  logic [BE_W-1:0] beb_eff, cbe_a, cbe_b;
  logic [AW-1:0]   cad_a;
  logic [DW-1:0]   cwd_a, crd_a, crd_b, fix_a, fix_b;
  logic [BE_W-1:0] fbe_a_q, fbe_a_d, fbe_b_q, fbe_b_d;
  logic [DW-1:0]   fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic            rv1a_q, rv1b_q, rv2a_q, rv2b_q, seen_a_q, seen_b_q;
  logic [DW-1:0]   rdo_a_q, rdo_a_d, rdo_b_q, rdo_b_d;
  always_comb begin
    clr     = st_q == ST_CLEAR;
    acc_a   = ready_q & ena;
    acc_b   = ready_q & enb;
    coll    = acc_a & acc_b & (aa == ab);
    beb_eff = coll ? web & ~wea : web;
    cnt_d   = clr ? cnt_q + 1'b1 : '0;
    st_d    = clr ? (&cnt_q ? ST_RUN : ST_CLEAR) : (clr_req & ready_q ? ST_CLEAR : ST_RUN);
    ready_d = st_d == ST_RUN;
    cbe_a   = clr ? '1 : (acc_a ? wea : '0);
    cbe_b   = acc_b ? beb_eff : '0;
    cad_a   = clr ? cnt_q : aa;
    cwd_a   = clr ? CLR_VAL : wda;
    // Each reader later folds in the other port's same-cycle write lanes.
    fbe_a_d = acc_a ? ((coll && (BYPASS != 0 || |wea)) ? beb_eff : '0) : fbe_a_q;
    fbe_b_d = acc_b ? ((coll && (BYPASS != 0 || |web)) ? wea : '0) : fbe_b_q;
    fwd_a_d = acc_a ? wdb : fwd_a_q;
    fwd_b_d = acc_b ? wda : fwd_b_q;
    rdo_a_d = rv1a_q ? fix_a : rdo_a_q;
    rdo_b_d = rv1b_q ? fix_b : rdo_b_q;
    ready   = ready_q;
    rva     = OUT_REG != 0 ? rv2a_q : rv1a_q;
    rvb     = OUT_REG != 0 ? rv2b_q : rv1b_q;
    rda     = OUT_REG != 0 ? rdo_a_q : ((seen_a_q | rv1a_q) ? fix_a : '0);
    rdb     = OUT_REG != 0 ? rdo_b_q : ((seen_b_q | rv1b_q) ? fix_b : '0);
  end
  for (genvar i = 0; i < BE_W; i++) begin : g_fix
    assign fix_a[8*i+:8] = merge_be(crd_a[8*i+:8], fwd_a_q[8*i+:8], fbe_a_q[i]);
    assign fix_b[8*i+:8] = merge_be(crd_b[8*i+:8], fwd_b_q[8*i+:8], fbe_b_q[i]);
  end
  dpram_core #(.DW(DW), .AW(AW)) u_core (
    .clk  (clk),
    .re_a (acc_a),
    .be_a (cbe_a),
    .ad_a (cad_a),
    .wd_a (cwd_a),
    .rd_a (crd_a),
    .re_b (acc_b),
    .be_b (cbe_b),
    .ad_b (ab),
    .wd_b (wdb),
    .rd_b (crd_b)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_RUN;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      fbe_a_q  <= '0;
      fbe_b_q  <= '0;
      fwd_a_q  <= '0;
      fwd_b_q  <= '0;
      rv1a_q   <= 1'b0;
      rv1b_q   <= 1'b0;
      rv2a_q   <= 1'b0;
      rv2b_q   <= 1'b0;
      seen_a_q <= 1'b0;
      seen_b_q <= 1'b0;
      rdo_a_q  <= '0;
      rdo_b_q  <= '0;
    end else begin
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      fbe_a_q  <= fbe_a_d;
      fbe_b_q  <= fbe_b_d;
      fwd_a_q  <= fwd_a_d;
      fwd_b_q  <= fwd_b_d;
      rv1a_q   <= acc_a;
      rv1b_q   <= acc_b;
      rv2a_q   <= rv1a_q;
      rv2b_q   <= rv1b_q;
      seen_a_q <= seen_a_q | rv1a_q;
      seen_b_q <= seen_b_q | rv1b_q;
      rdo_a_q  <= rdo_a_d;
      rdo_b_q  <= rdo_b_d;
    end
  end
endmodule
